// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, counter and state definitions for div_reconstruct
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD
  } state_t;

endpackage

// File: rtl/div_reconstruct_if.sv
// rtl/div_reconstruct_if.sv - operand load, handshake and result bundle for div_reconstruct
interface div_reconstruct_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_b;
  logic [WIDTH-1:0] d_r;
  logic             en_q;
  logic             en_b;
  logic             en_r;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             rem_err;

  modport master (
    output d_q, d_b, d_r, en_q, en_b, en_r, start,
    input  busy, done, result, overflow, rem_err
  );

  modport slave (
    input  d_q, d_b, d_r, en_q, en_b, en_r, start,
    output busy, done, result, overflow, rem_err
  );

endinterface

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - shift-add multiplier datapath, one partial product per step
module mul_shift_add_dp
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, b};
      mplier <= q;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/div_reconstruct.sv
// rtl/div_reconstruct.sv - rebuilds a dividend as q*b+r and flags overflow / invalid remainder
module div_reconstruct
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic              clk,
  input logic              rstn,
  div_reconstruct_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [WIDTH-1:0]   radd;
  logic [WIDTH-1:0]   b_snap;
  logic [CNT_W-1:0]   cnt;
  state_t             state;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   result_r;
  logic               overflow_r;
  logic               rem_err_r;
  logic               dp_load;
  logic               dp_step;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
    end else begin
      if (bus.en_q) q_reg <= bus.d_q;
      if (bus.en_b) b_reg <= bus.d_b;
      if (bus.en_r) r_reg <= bus.d_r;
    end
  end

  assign dp_load = (state == IDLE) && bus.start;
  assign dp_step = (state == MUL);

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk  (clk),
    .rstn (rstn),
    .load (dp_load),
    .step (dp_step),
    .q    (q_reg),
    .b    (b_reg),
    .acc  (acc)
  );

  // (2^W-1)^2 + (2^W-1) still fits in 2W bits, so this sum never wraps.
  assign full = acc + {{WIDTH{1'b0}}, radd};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      radd       <= '0;
      b_snap     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= '0;
      overflow_r <= 1'b0;
      rem_err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            radd   <= r_reg;
            b_snap <= b_reg;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ADD;
          end
        end
        ADD: begin
          result_r   <= full[WIDTH-1:0];
          overflow_r <= |full[2*WIDTH-1:WIDTH];
          rem_err_r  <= (radd >= b_snap);
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.overflow = overflow_r;
  assign bus.rem_err  = rem_err_r;

endmodule

// File: tb/tb_div_reconstruct.sv
// tb/tb_div_reconstruct.sv - directed self-checking bench for div_reconstruct
module tb_div_reconstruct;

  localparam int W = 16;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  div_reconstruct_if #(.WIDTH(W)) bus ();

  div_reconstruct #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r);
    bus.d_q = q; bus.d_b = b; bus.d_r = r;
    bus.en_q = 1'b1; bus.en_b = 1'b1; bus.en_r = 1'b1;
    tick();
    bus.en_q = 1'b0; bus.en_b = 1'b0; bus.en_r = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns edges waited until done and number of sampled busy-high points (incl. the one right after start).
  task automatic wait_done(output bit found, output int cyc, output int busy_cnt);
    found    = 1'b0;
    cyc      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc++;
      if (bus.done) begin
        found = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] exp_res, input logic exp_ov, input logic exp_re);
    bit found;
    int cyc;
    int bc;
    pulse_start();
    wait_done(found, cyc, bc);
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ov));
    check({tag, "_rem_err"}, 32'(bus.rem_err), 32'(exp_re));
  endtask

  task automatic expect_no_done(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.done) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    bit found;
    int cyc;
    int bc;
    n_cmp = 0;
    n_err = 0;
    rstn = 1'b0;
    bus.d_q = '0; bus.d_b = '0; bus.d_r = '0;
    bus.en_q = 1'b0; bus.en_b = 1'b0; bus.en_r = 1'b0;
    bus.start = 1'b0;
    repeat (3) tick();
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_rem_err", 32'(bus.rem_err), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rstn = 1'b1;
    tick();

    // 2*50+0, with latency and busy width
    load_all(16'd2, 16'd50, 16'd0);
    pulse_start();
    wait_done(found, cyc, bc);
    check("t1_done_seen", 32'(found), 32'd1);
    check("t1_latency", 32'(cyc), 32'd17);
    check("t1_busy_cycles", 32'(bc), 32'd17);
    check("t1_result", 32'(bus.result), 32'd100);
    check("t1_overflow", 32'(bus.overflow), 32'd0);
    check("t1_rem_err", 32'(bus.rem_err), 32'd0);
    check("t1_busy_at_done", 32'(bus.busy), 32'd0);
    tick();
    check("t1_done_width", 32'(bus.done), 32'd0);
    check("t1_result_hold", 32'(bus.result), 32'd100);

    load_all(16'd3, 16'd5, 16'd2);
    run("t2", 16'd17, 1'b0, 1'b0);
    load_all(16'd255, 16'd256, 16'd255);
    run("t3", 16'd65535, 1'b0, 1'b0);

    // 0xFFFE0001: low half 1, high half nonzero; r=0 < b so remainder is valid
    load_all(16'hFFFF, 16'hFFFF, 16'd0);
    run("t4", 16'd1, 1'b1, 1'b0);
    load_all(16'd1, 16'd5, 16'd7);
    run("t5", 16'd12, 1'b0, 1'b1);
    load_all(16'd9, 16'd0, 16'd4);
    run("t6", 16'd4, 1'b0, 1'b1);

    // Load and re-start while busy: computation in flight is unaffected
    load_all(16'd2, 16'd50, 16'd0);
    pulse_start();
    repeat (3) tick();
    bus.d_q = 16'd100; bus.en_q = 1'b1; bus.start = 1'b1;
    tick();
    bus.en_q = 1'b0; bus.start = 1'b0;
    wait_done(found, cyc, bc);
    check("t7_done_seen", 32'(found), 32'd1);
    check("t7_result", 32'(bus.result), 32'd100);
    expect_no_done("t7_no_second_done", 25);
    check("t7_idle", 32'(bus.busy), 32'd0);
    run("t8", 16'd5000, 1'b0, 1'b0);

    // Reset in the middle of MUL
    load_all(16'd7, 16'd9, 16'd1);
    pulse_start();
    repeat (8) tick();
    rstn = 1'b0;
    #1;
    check("t9_rst_busy", 32'(bus.busy), 32'd0);
    check("t9_rst_result", 32'(bus.result), 32'd0);
    check("t9_rst_done", 32'(bus.done), 32'd0);
    tick();
    rstn = 1'b1;
    expect_no_done("t9_no_done", 25);
    load_all(16'd441, 16'd123, 16'd78);
    run("t10", 16'd54321, 1'b0, 1'b0);

    // en_q on the start edge: snapshot uses the old q
    load_all(16'd3, 16'd5, 16'd2);
    bus.d_q = 16'd7; bus.en_q = 1'b1; bus.start = 1'b1;
    tick();
    bus.en_q = 1'b0; bus.start = 1'b0;
    wait_done(found, cyc, bc);
    check("t11_done_seen", 32'(found), 32'd1);
    check("t11_result", 32'(bus.result), 32'd17);
    run("t12", 16'd37, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
